// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared FSM state type and counter sizing for the serial deserializer
package serial_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // One extra bit over clog2 keeps the count of received bits representable at WIDTH.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/out_hold_reg.sv
// rtl/out_hold_reg.sv - one-entry valid/ready word buffer with drop detection and sticky overflow
module out_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             out_ready,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             overflow
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    drop    = 1'b0;
    if (in_valid) begin
      // A word arriving while the consumer drains the old one loads with no bubble.
      if (!valid_q || out_ready) begin
        data_d  = in_data;
        valid_d = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Set takes priority over clear so a drop is never lost.
  always_comb begin
    ovf_d = ovf_q;
    if (clr_ovf) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign overflow  = ovf_q;

endmodule

// File: rtl/serial_deserializer.sv
// rtl/serial_deserializer.sv - sync-framed serial-to-parallel word assembler feeding a one-entry output buffer
module serial_deserializer
  import serial_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sdi,
  input  logic             en,
  input  logic             sync,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow,
  input  logic             clr_ovf
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             word_done;

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] base, input logic b);
    if (MSB_FIRST) return {base[WIDTH-2:0], b};
    else           return {b, base[WIDTH-1:1]};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

  // Once framed, the deserializer never returns to IDLE except through reset.
  always_comb begin
    state_d = state_q;
    if (sync) state_d = SHIFT;
  end

  always_comb begin
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    word_done = 1'b0;
    if (sync) begin
      // Resync discards any partial word; the strobe's own bit starts the new one.
      cnt_d   = en ? CW'(1) : '0;
      shreg_d = en ? shift_in('0, sdi) : '0;
    end else if (state_q == SHIFT && en) begin
      shreg_d = shift_in(shreg_q, sdi);
      if (cnt_q == LAST_BIT) begin
        cnt_d     = '0;
        word_done = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  out_hold_reg #(
    .WIDTH(WIDTH)
  ) u_out_hold_reg (
    .clk      (clk),
    .rst      (rst),
    .in_valid (word_done),
    .in_data  (shreg_d),
    .out_ready(out_ready),
    .clr_ovf  (clr_ovf),
    .out_data (out_data),
    .out_valid(out_valid),
    .overflow (overflow)
  );

endmodule

// File: tb/tb_serial_deserializer.sv
// tb/tb_serial_deserializer.sv - directed self-checking bench for serial_deserializer, MSB- and LSB-first instances
module tb_serial_deserializer;

  logic       clk = 1'b0;
  logic       rst, sdi, en, sync, out_ready, clr_ovf;
  logic [7:0] data_m, data_l;
  logic       valid_m, valid_l, ovf_m, ovf_l;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  serial_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .sdi(sdi), .en(en), .sync(sync),
    .out_data(data_m), .out_valid(valid_m), .out_ready(out_ready),
    .overflow(ovf_m), .clr_ovf(clr_ovf)
  );

  serial_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .sdi(sdi), .en(en), .sync(sync),
    .out_data(data_l), .out_valid(valid_l), .out_ready(out_ready),
    .overflow(ovf_l), .clr_ovf(clr_ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic s);
    sdi  = b;
    en   = 1'b1;
    sync = s;
    tick();
    en   = 1'b0;
    sync = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; sdi = 1'b0; en = 1'b0; sync = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
    tick(); tick();
    rst = 1'b0;
    checks++; if ({valid_m, valid_l} !== 2'b00) begin failures++; $display("FAIL reset_valid got=%b exp=00", {valid_m, valid_l}); end
    checks++; if ({data_m, data_l} !== 16'h0000) begin failures++; $display("FAIL reset_data got=%h exp=0000", {data_m, data_l}); end
    checks++; if ({ovf_m, ovf_l} !== 2'b00) begin failures++; $display("FAIL reset_ovf got=%b exp=00", {ovf_m, ovf_l}); end
  endtask

  task automatic test_word_a5();
    logic [7:0] bits;
    int early;
    bits = 8'b1010_0101;
    early = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_bit(bits[7-i], i == 0);
      if (i < 7 && valid_m !== 1'b0) early++;
    end
    checks++; if (early != 0) begin failures++; $display("FAIL a5_early_valid got=%0d exp=0", early); end
    checks++; if ({valid_m, valid_l} !== 2'b11) begin failures++; $display("FAIL a5_valid got=%b exp=11", {valid_m, valid_l}); end
    checks++; if (data_m !== 8'hA5) begin failures++; $display("FAIL a5_msb_data got=%h exp=a5", data_m); end
    checks++; if (data_l !== 8'hA5) begin failures++; $display("FAIL a5_lsb_data got=%h exp=a5", data_l); end
    tick();
    checks++; if ({valid_m, valid_l} !== 2'b00) begin failures++; $display("FAIL a5_one_cycle got=%b exp=00", {valid_m, valid_l}); end
  endtask

  task automatic test_bit_order();
    logic [7:0] bits;
    bits = 8'b1100_0000;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send_bit(bits[7-i], i == 0);
    checks++; if (data_m !== 8'hC0) begin failures++; $display("FAIL order_msb got=%h exp=c0", data_m); end
    checks++; if (data_l !== 8'h03) begin failures++; $display("FAIL order_lsb got=%h exp=03", data_l); end
    tick();
  endtask

  task automatic test_overflow();
    logic [7:0] w0, w1;
    w0 = 8'h3C;
    w1 = 8'hC3;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send_bit(w0[7-i], i == 0);
      for (int g = 0; g < (i % 4); g++) tick();
    end
    checks++; if ({valid_m, ovf_m, data_m} !== {1'b1, 1'b0, 8'h3C}) begin failures++; $display("FAIL ovf_first got=%b/%b/%h exp=1/0/3c", valid_m, ovf_m, data_m); end
    for (int i = 0; i < 8; i++) begin
      send_bit(w1[7-i], 1'b0);
      for (int g = 0; g < ((i + 1) % 4); g++) tick();
    end
    checks++; if (data_m !== 8'h3C || data_l !== 8'h3C) begin failures++; $display("FAIL ovf_held got=%h/%h exp=3c/3c", data_m, data_l); end
    checks++; if ({ovf_m, ovf_l} !== 2'b11) begin failures++; $display("FAIL ovf_set got=%b exp=11", {ovf_m, ovf_l}); end
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    checks++; if ({ovf_m, ovf_l, valid_m} !== 3'b001) begin failures++; $display("FAIL ovf_clear got=%b exp=001", {ovf_m, ovf_l, valid_m}); end
    out_ready = 1'b1;
    tick();
    checks++; if ({valid_m, data_m} !== {1'b0, 8'h3C}) begin failures++; $display("FAIL ovf_drain got=%b/%h exp=0/3c", valid_m, data_m); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w0, w1;
    w0 = 8'h5A;
    w1 = 8'h96;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_bit(w0[7-i], i == 0);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) out_ready = 1'b1;
      send_bit(w1[7-i], 1'b0);
    end
    checks++; if ({valid_m, data_m} !== {1'b1, 8'h96}) begin failures++; $display("FAIL b2b_msb got=%b/%h exp=1/96", valid_m, data_m); end
    checks++; if ({valid_l, data_l} !== {1'b1, 8'h69}) begin failures++; $display("FAIL b2b_lsb got=%b/%h exp=1/69", valid_l, data_l); end
    checks++; if ({ovf_m, ovf_l} !== 2'b00) begin failures++; $display("FAIL b2b_ovf got=%b exp=00", {ovf_m, ovf_l}); end
    tick();
    checks++; if (valid_m !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", valid_m); end
  endtask

  task automatic test_resync();
    logic [7:0] w;
    int seen;
    w = 8'h81;
    seen = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send_bit(1'b1, i == 0);
      if (valid_m !== 1'b0) seen++;
    end
    for (int i = 0; i < 8; i++) begin
      send_bit(w[7-i], i == 0);
      if (i < 7 && valid_m !== 1'b0) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL resync_partial got=%0d exp=0", seen); end
    checks++; if ({valid_m, data_m, data_l} !== {1'b1, 8'h81, 8'h81}) begin failures++; $display("FAIL resync_word got=%b/%h/%h exp=1/81/81", valid_m, data_m, data_l); end
    tick();
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] w;
    int seen;
    w = 8'hA5;
    seen = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_bit(w[7-i], i == 0);
    for (int i = 0; i < 8; i++) send_bit(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0);
    checks++; if ({valid_m, ovf_m} !== 2'b11) begin failures++; $display("FAIL rstmid_pre got=%b exp=11", {valid_m, ovf_m}); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({valid_m, valid_l, ovf_m, ovf_l, data_m, data_l} !== 20'h0) begin failures++; $display("FAIL rstmid_outputs got=%h exp=00000", {valid_m, valid_l, ovf_m, ovf_l, data_m, data_l}); end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send_bit(i[0], 1'b0);
      if (valid_m !== 1'b0 || valid_l !== 1'b0) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL rstmid_idle got=%0d exp=0", seen); end
  endtask

  initial begin
    test_reset();
    test_word_a5();
    test_bit_order();
    test_overflow();
    test_back_to_back();
    test_resync();
    test_reset_mid_word();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
